zeroheti_obi_arbiter: RTL
=========================

Name: zeroheti_obi_arbiter

Overview:
- Two-manager to one-subordinate OBI arbiter.
- Shares the single subordinate port (system interconnect / memory) between the core data manager (m0) and the debug module's system-bus-access manager (m1).
- Routes in-order responses back to their originating manager using an ID FIFO.
- Bounds the number of outstanding transactions.

Parameters:
AddrWidth, 32, address width of all OBI ports
DataWidth, 32, data width; byte-enable width is DataWidth/8
MaxOutstanding, 2, depth of the response-routing FIFO (power of two, >=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
dbg_prio_i  in  1  1: m1 has fixed priority over m0; 0: round-robin
m0_req_i  in  1  core request
m0_gnt_o  out  1  core grant
m0_addr_i / m0_we_i / m0_be_i / m0_wdata_i  in  AddrWidth/1/DataWidth/8/DataWidth  core request payload
m0_rvalid_o / m0_rdata_o / m0_err_o  out  1/DataWidth/1  core response
m1_*  same set as m0_*  SBA manager
s_req_o  out  1  subordinate request
s_gnt_i  in  1  subordinate grant
s_addr_o / s_we_o / s_be_o / s_wdata_o  out  as above  selected payload
s_rvalid_i / s_rdata_i / s_err_i  in  1/DataWidth/1  subordinate response
busy_o  out  1  outstanding count != 0
unexp_rsp_o  out  1  sticky: s_rvalid_i seen with FIFO empty

Behaviour:
- Clocking/reset: all state updates on rising clk_i. rst_i synchronous active-high.
- Reset clears rr pointer (to m0 favoured), lock, FIFO, count and unexp_rsp_o.
- During and directly after reset all outputs are 0: s_req_o, gnts, rvalids, busy_o, unexp_rsp_o.
- Request path: combinational, zero latency. s_req_o = selected m*_req_i && !full && !rst_i. Payload muxed from the selected manager. Grant: m{sel}_gnt_o = s_gnt_i && s_req_o; the other gnt is 0.
- Selection when unlocked:
  - dbg_prio_i=1: m1 wins if requesting, else m0.
  - dbg_prio_i=0: on conflict the manager not granted last wins; a single requester always wins.
  - rr pointer updates only on a handshake (s_req_o && s_gnt_i).
- Lock: if s_req_o=1 and s_gnt_i=0, the selection register holds the current manager next cycle regardless of new requests or dbg_prio_i changes. OBI forbids retracting a request, so arbitration never switches mid-request. Lock releases on handshake.
- Full: count==MaxOutstanding (registered) forces s_req_o=0 and both gnts 0. A pop in the same cycle does not unblock until the next cycle.
- Response FIFO:
  - Push selected ID on handshake; pop on s_rvalid_i.
  - Push and pop in the same cycle leave count unchanged.
  - Count width clog2(MaxOutstanding)+1. Pointers wrap modulo MaxOutstanding.
- Response path: combinational, same cycle. m{head}_rvalid_o = s_rvalid_i; rdata/err broadcast to both managers, qualified by rvalid. Responses arrive in order.
- Unexpected response: s_rvalid_i with count==0. No rvalid is forwarded, unexp_rsp_o is set, count stays 0.
- Reset mid-operation: outstanding transactions are abandoned; late responses set unexp_rsp_o.
- busy_o is registered: busy_o = (count != 0).

Test Plan:
- Only m0 requests, addr 0x1000, s_gnt_i=1 same cycle, rvalid next cycle, rdata 0xDEADBEEF -> m0_gnt_o=1 cycle 0; m0_rvalid_o=1, m0_rdata_o=0xDEADBEEF cycle 1; m1_rvalid_o=0.
- dbg_prio_i=0, both requesting every cycle, s_gnt_i=1 -> grants alternate m0,m1,m0,m1. With dbg_prio_i=1 -> m1 granted every cycle.
- m0 requests, s_gnt_i held 0 for 3 cycles while m1 asserts and dbg_prio_i=1 -> s_addr_o stays at m0's address, m0 granted on cycle 4, m1 granted only afterwards.
- MaxOutstanding=2, two grants with no rvalid -> third request sees s_req_o=0. rvalid in cycle N -> s_req_o reasserts in N+1. Responses go to the original IDs in order (m1 then m0 when issued m1, m0).
- s_rvalid_i pulse after reset with no traffic -> no m*_rvalid_o, unexp_rsp_o=1 and stays 1 until rst_i.
- rst_i asserted with 2 outstanding -> next cycle busy_o=0, count 0. Following s_rvalid_i sets unexp_rsp_o; new m0 request is granted normally.

Source files
------------

// File: rtl/zeroheti_obi_arbiter.sv
// Two-manager to one-subordinate OBI arbiter.
// An ID FIFO routes in-order responses back to the manager that issued each request.
module zeroheti_obi_arbiter #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   dbg_prio_i,
  input  logic                   m0_req_i,
  output logic                   m0_gnt_o,
  input  logic [AddrWidth-1:0]   m0_addr_i,
  input  logic                   m0_we_i,
  input  logic [DataWidth/8-1:0] m0_be_i,
  input  logic [DataWidth-1:0]   m0_wdata_i,
  output logic                   m0_rvalid_o,
  output logic [DataWidth-1:0]   m0_rdata_o,
  output logic                   m0_err_o,
  input  logic                   m1_req_i,
  output logic                   m1_gnt_o,
  input  logic [AddrWidth-1:0]   m1_addr_i,
  input  logic                   m1_we_i,
  input  logic [DataWidth/8-1:0] m1_be_i,
  input  logic [DataWidth-1:0]   m1_wdata_i,
  output logic                   m1_rvalid_o,
  output logic [DataWidth-1:0]   m1_rdata_o,
  output logic                   m1_err_o,
  output logic                   s_req_o,
  input  logic                   s_gnt_i,
  output logic [AddrWidth-1:0]   s_addr_o,
  output logic                   s_we_o,
  output logic [DataWidth/8-1:0] s_be_o,
  output logic [DataWidth-1:0]   s_wdata_o,
  input  logic                   s_rvalid_i,
  input  logic [DataWidth-1:0]   s_rdata_i,
  input  logic                   s_err_i,
  output logic                   busy_o,
  output logic                   unexp_rsp_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic                      r_locked;
  logic                      r_lockSel;
  logic                      r_rrFav;
  logic [MaxOutstanding-1:0] r_idFifo;
  logic [PtrW-1:0]           r_wPtr;
  logic [PtrW-1:0]           r_rPtr;
  logic [CntW-1:0]           r_count;
  logic                      r_busy;
  logic                      r_unexp;

  logic            w_sel;
  logic            w_selReq;
  logic            w_full;
  logic            w_hs;
  logic            w_pop;
  logic            w_head;
  logic [CntW-1:0] w_cntNext;

  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) return '0;
    return p + 1'b1;
  endfunction

  // A stalled request keeps its manager selected: OBI forbids retracting it.
  always_comb begin
    w_sel = 1'b0;
    if (r_locked)                   w_sel = r_lockSel;
    else if (dbg_prio_i)            w_sel = m1_req_i;
    else if (m0_req_i && m1_req_i)  w_sel = r_rrFav;
    else                            w_sel = m1_req_i;
  end

  assign w_full   = (r_count == CntW'(MaxOutstanding));
  assign w_selReq = w_sel ? m1_req_i : m0_req_i;
  assign s_req_o  = w_selReq && !w_full && !rst_i;
  assign w_hs     = s_req_o && s_gnt_i;
  assign m0_gnt_o = w_hs && !w_sel;
  assign m1_gnt_o = w_hs && w_sel;

  assign s_addr_o  = w_sel ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = w_sel ? m1_we_i    : m0_we_i;
  assign s_be_o    = w_sel ? m1_be_i    : m0_be_i;
  assign s_wdata_o = w_sel ? m1_wdata_i : m0_wdata_i;

  assign w_pop  = s_rvalid_i && (r_count != '0) && !rst_i;
  assign w_head = r_idFifo[r_rPtr];

  assign m0_rvalid_o = w_pop && !w_head;
  assign m1_rvalid_o = w_pop && w_head;
  assign m0_rdata_o  = w_pop ? s_rdata_i : '0;
  assign m1_rdata_o  = w_pop ? s_rdata_i : '0;
  assign m0_err_o    = w_pop && s_err_i;
  assign m1_err_o    = w_pop && s_err_i;

  always_comb begin
    w_cntNext = r_count;
    case ({w_hs, w_pop})
      2'b10:   w_cntNext = r_count + 1'b1;
      2'b01:   w_cntNext = r_count - 1'b1;
      default: w_cntNext = r_count;
    endcase
  end

  assign busy_o      = r_busy && !rst_i;
  assign unexp_rsp_o = r_unexp && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_locked  <= 1'b0;
      r_lockSel <= 1'b0;
      r_rrFav   <= 1'b0;
      r_idFifo  <= '0;
      r_wPtr    <= '0;
      r_rPtr    <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_unexp   <= 1'b0;
    end else begin
      if (w_hs) begin
        r_idFifo[r_wPtr] <= w_sel;
        r_wPtr           <= nextPtr(r_wPtr);
        r_rrFav          <= ~w_sel;
      end
      if (w_pop) r_rPtr <= nextPtr(r_rPtr);
      r_count   <= w_cntNext;
      r_busy    <= (w_cntNext != '0);
      r_locked  <= s_req_o && !s_gnt_i;
      r_lockSel <= w_sel;
      if (s_rvalid_i && (r_count == '0)) r_unexp <= 1'b1;
    end
  end

endmodule
